cpu_run_ctrl: RTL and testbench

// - Execution controller sitting between the front-panel run buttons and the CPU core.
// - Turns NEXT / RUN / SPEEDRUN / edit levels into a single-cycle CPU advance enable, step_en.
// - Adds what the fixed-rate controls lack: a programmable run-rate divider, a CPU halt input,
//   a saturating executed-step counter and optional PC breakpoints.

---
 rtl/cpu_run_pkg.sv | 16 +
 rtl/cpu_run_ctrl_bp_match.sv | 37 +++
 rtl/cpu_run_ctrl.sv | 129 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared state encoding for the CPU run controller; the state code is also the mode output.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SPEED  = 3'd2,
    ST_HALTED = 3'd3,
    ST_EDIT   = 3'd4
  } run_state_e;

  function automatic logic is_running(input run_state_e s);
    return (s == ST_RUN) || (s == ST_SPEED);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_bp_match.sv
// Breakpoint slot registers with a parallel PC compare; instantiated only when
// CPU_BREAKPOINT_EN is defined. NUM_BP must be at least 2.
module run_bp_match #(
  parameter int PC_W   = 8,
  parameter int NUM_BP = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bp_we,
  input  logic [$clog2(NUM_BP)-1:0] bp_idx,
  input  logic [PC_W-1:0]           bp_addr,
  input  logic                      bp_valid,
  input  logic [PC_W-1:0]           pc,
  output logic                      match
);

  logic [PC_W-1:0]   slot_addr [NUM_BP];
  logic [NUM_BP-1:0] slot_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_addr  <= '{default: '0};
      slot_valid <= '0;
    end else if (bp_we) begin
      slot_addr[bp_idx]  <= bp_addr;
      slot_valid[bp_idx] <= bp_valid;
    end
  end

  always_comb begin
    match = 1'b0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (slot_valid[i] && (slot_addr[i] == pc)) match = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Front-panel execution controller: NEXT/RUN/SPEEDRUN/edit -> registered step_en.
// Define CPU_BREAKPOINT_EN to enable the PC breakpoint slots (run_bp_match).
module cpu_run_ctrl #(
  parameter int PC_W    = 8,
  parameter int DIV_W   = 8,
  parameter int RUN_DIV = 4,
  parameter int CNT_W   = 16,
  parameter int NUM_BP  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      NEXT,
  input  logic                      RUN,
  input  logic                      SPEEDRUN,
  input  logic                      edit,
  input  logic                      halt_req,
  input  logic [PC_W-1:0]           pc,
  input  logic                      clr_cnt,
  input  logic                      bp_we,
  input  logic [$clog2(NUM_BP)-1:0] bp_idx,
  input  logic [PC_W-1:0]           bp_addr,
  input  logic                      bp_valid,
  output logic                      step_en,
  output logic [2:0]                mode,
  output logic [CNT_W-1:0]          step_cnt,
  output logic                      bp_hit
);
  import cpu_run_pkg::*;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  run_state_e       state, state_nx;
  logic             next_q, run_q, speed_q;
  logic             next_edge, run_edge, speed_edge;
  logic [DIV_W-1:0] div_q, div_nx;
  logic             step_nx, hit_nx, step_due, bp_match;

  assign next_edge  = NEXT & ~next_q;
  assign run_edge   = RUN & ~run_q;
  assign speed_edge = SPEEDRUN & ~speed_q;
  assign mode       = state;

`ifdef CPU_BREAKPOINT_EN
  run_bp_match #(
    .PC_W  (PC_W),
    .NUM_BP(NUM_BP)
  ) u_bp_match (
    .clk     (clk),
    .rst     (rst),
    .bp_we   (bp_we),
    .bp_idx  (bp_idx),
    .bp_addr (bp_addr),
    .bp_valid(bp_valid),
    .pc      (pc),
    .match   (bp_match)
  );
`else
  logic unused_bp;
  assign unused_bp = ^{bp_we, bp_idx, bp_addr, bp_valid, pc};
  assign bp_match  = 1'b0;
`endif

  // Divider defaults to zero so any state change clears it; only RUN->RUN advances it.
  always_comb begin
    state_nx = state;
    div_nx   = '0;
    step_nx  = 1'b0;
    hit_nx   = 1'b0;
    step_due = (state == ST_SPEED) || ((state == ST_RUN) && (div_q == DIV_LAST));
    if (edit) begin
      state_nx = ST_EDIT;
    end else if (state == ST_EDIT) begin
      state_nx = ST_IDLE;
    end else if (halt_req && (state != ST_HALTED)) begin
      state_nx = ST_HALTED;
    end else if (is_running(state) && step_due && bp_match) begin
      state_nx = ST_HALTED;
      hit_nx   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (speed_edge)     state_nx = ST_SPEED;
          else if (run_edge)  state_nx = ST_RUN;
          else if (next_edge) step_nx  = 1'b1;
        end
        ST_RUN: begin
          if (speed_edge)    state_nx = ST_SPEED;
          else if (run_edge) state_nx = ST_IDLE;
          else begin
            step_nx = step_due;
            div_nx  = step_due ? '0 : div_q + 1'b1;
          end
        end
        ST_SPEED: begin
          if (speed_edge || run_edge) state_nx = ST_IDLE;
          else                        step_nx  = 1'b1;
        end
        ST_HALTED: begin
          if (next_edge || run_edge || speed_edge) state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      div_q    <= '0;
      step_en  <= 1'b0;
      bp_hit   <= 1'b0;
      next_q   <= 1'b0;
      run_q    <= 1'b0;
      speed_q  <= 1'b0;
      step_cnt <= '0;
    end else begin
      state   <= state_nx;
      div_q   <= div_nx;
      step_en <= step_nx;
      bp_hit  <= hit_nx;
      next_q  <= NEXT;
      run_q   <= RUN;
      speed_q <= SPEEDRUN;
      if (clr_cnt)                         step_cnt <= '0;
      else if (step_en && (step_cnt != '1)) step_cnt <= step_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl (RUN_DIV=4, CNT_W=4); breakpoint scenario follows CPU_BREAKPOINT_EN.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  logic clk = 1'b0, rst = 1'b0;
  logic NEXT = 1'b0, RUN = 1'b0, SPEEDRUN = 1'b0, edit = 1'b0, halt_req = 1'b0;
  logic clr_cnt = 1'b0, bp_we = 1'b0, bp_valid = 1'b0;
  logic [7:0] pc = '0, bp_addr = '0;
  logic [1:0] bp_idx = '0;
  logic       step_en, bp_hit;
  logic [2:0] mode;
  logic [3:0] step_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic step; logic [2:0] mode; logic bp;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .PC_W(8), .DIV_W(8), .RUN_DIV(4), .CNT_W(4), .NUM_BP(4)
  ) dut (
    .clk(clk), .rst(rst), .NEXT(NEXT), .RUN(RUN), .SPEEDRUN(SPEEDRUN), .edit(edit),
    .halt_req(halt_req), .pc(pc), .clr_cnt(clr_cnt), .bp_we(bp_we), .bp_idx(bp_idx),
    .bp_addr(bp_addr), .bp_valid(bp_valid), .step_en(step_en), .mode(mode),
    .step_cnt(step_cnt), .bp_hit(bp_hit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic s, input run_state_e m, input logic b);
    exp_t e;
    e.step = s;
    e.mode = m;
    e.bp   = b;
    return e;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({step_en, mode, bp_hit, step_cnt} !== 9'b0) begin
      errors++;
      $display("FAIL reset: step_en/mode/bp_hit/cnt got %b/%0d/%b/%0d exp 0/0/0/0",
               step_en, mode, bp_hit, step_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_next();
    exp_t e;
    // NEXT held 2 clocks, low, then a second short pulse
    for (int i = 0; i < 7; i++) begin
      NEXT = (i < 2) || (i == 4);
      sb.push_back(mk((i == 0) || (i == 4), ST_IDLE, 1'b0));
      tick();
      e = sb.pop_front();
      checks++;
      if ({step_en, mode, bp_hit} !== e) begin
        errors++;
        $display("FAIL next[%0d]: step_en/mode/bp_hit got %b/%0d/%b exp %b/%0d/%b",
                 i, step_en, mode, bp_hit, e.step, e.mode, e.bp);
      end
      if (i == 3) begin
        checks++;
        if (step_cnt !== 4'd1) begin
          errors++;
          $display("FAIL next_cnt: step_cnt got %0d exp 1", step_cnt);
        end
      end
    end
    checks++;
    if (step_cnt !== 4'd2) begin
      errors++;
      $display("FAIL next_cnt2: step_cnt got %0d exp 2", step_cnt);
    end
  endtask

  task automatic test_run();
    exp_t e;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int i = 0; i < 44; i++) begin
      RUN = (i <= 40) || (i == 42);
      sb.push_back(mk((i >= 1) && (i <= 40) && (i % 4 == 0), (i < 42) ? ST_RUN : ST_IDLE, 1'b0));
      tick();
      e = sb.pop_front();
      checks++;
      if ({step_en, mode, bp_hit} !== e) begin
        errors++;
        $display("FAIL run[%0d]: step_en/mode/bp_hit got %b/%0d/%b exp %b/%0d/%b",
                 i, step_en, mode, bp_hit, e.step, e.mode, e.bp);
      end
    end
    checks++;
    if (step_cnt !== 4'd10) begin
      errors++;
      $display("FAIL run_cnt: step_cnt got %0d exp 10", step_cnt);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    logic [2:0] stim [7] = '{3'b110, 3'b000, 3'b011, 3'b000, 3'b100, 3'b010, 3'b000};
    exp_t       want [7];
    want = '{mk(0, ST_RUN, 0), mk(0, ST_RUN, 0), mk(0, ST_SPEED, 0), mk(1, ST_SPEED, 0),
             mk(1, ST_SPEED, 0), mk(0, ST_IDLE, 0), mk(0, ST_IDLE, 0)};
    for (int i = 0; i < 7; i++) begin
      {NEXT, RUN, SPEEDRUN} = stim[i];
      sb.push_back(want[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({step_en, mode, bp_hit} !== e) begin
        errors++;
        $display("FAIL prio[%0d]: step_en/mode/bp_hit got %b/%0d/%b exp %b/%0d/%b",
                 i, step_en, mode, bp_hit, e.step, e.mode, e.bp);
      end
    end
  endtask

  task automatic test_speed_halt();
    exp_t e;
    int   exp_c;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int i = 0; i < 25; i++) begin
      SPEEDRUN = (i == 0);
      halt_req = (i == 21);
      NEXT     = (i == 23);
      if (i == 0)       sb.push_back(mk(0, ST_SPEED, 0));
      else if (i <= 20) sb.push_back(mk(1, ST_SPEED, 0));
      else if (i <= 22) sb.push_back(mk(0, ST_HALTED, 0));
      else              sb.push_back(mk(0, ST_IDLE, 0));
      tick();
      e = sb.pop_front();
      checks++;
      if ({step_en, mode, bp_hit} !== e) begin
        errors++;
        $display("FAIL speed[%0d]: step_en/mode/bp_hit got %b/%0d/%b exp %b/%0d/%b",
                 i, step_en, mode, bp_hit, e.step, e.mode, e.bp);
      end
      if ((i >= 1) && (i <= 21)) begin
        exp_c = (i - 1 > 15) ? 15 : i - 1;
        checks++;
        if (step_cnt !== exp_c[3:0]) begin
          errors++;
          $display("FAIL sat_cnt[%0d]: step_cnt got %0d exp %0d", i, step_cnt, exp_c);
        end
      end
    end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++;
    if (step_cnt !== 4'd0) begin
      errors++;
      $display("FAIL clr_cnt: step_cnt got %0d exp 0", step_cnt);
    end
  endtask

  task automatic test_edit();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      SPEEDRUN = (i == 0);
      edit     = (i == 2) || (i == 3);
      NEXT     = (i == 3);
      if (i == 0)      sb.push_back(mk(0, ST_SPEED, 0));
      else if (i == 1) sb.push_back(mk(1, ST_SPEED, 0));
      else if (i <= 3) sb.push_back(mk(0, ST_EDIT, 0));
      else             sb.push_back(mk(0, ST_IDLE, 0));
      tick();
      e = sb.pop_front();
      checks++;
      if ({step_en, mode, bp_hit} !== e) begin
        errors++;
        $display("FAIL edit[%0d]: step_en/mode/bp_hit got %b/%0d/%b exp %b/%0d/%b",
                 i, step_en, mode, bp_hit, e.step, e.mode, e.bp);
      end
    end
  endtask

  task automatic test_reset_midrun();
    SPEEDRUN = 1'b1;
    tick();
    SPEEDRUN = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({step_en, mode, step_cnt} !== 8'b0) begin
      errors++;
      $display("FAIL reset_mid: step_en/mode/cnt got %b/%0d/%0d exp 0/0/0", step_en, mode, step_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (step_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: step_en got %b exp 0", i, step_en);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if ({step_en, mode} !== 4'b0) begin
      errors++;
      $display("FAIL reset_rel: step_en/mode got %b/%0d exp 0/0", step_en, mode);
    end
  endtask

  task automatic test_breakpoint();
    exp_t e;
    bp_we = 1'b1; bp_idx = 2'd0; bp_addr = 8'h05; bp_valid = 1'b1;
    tick();
    bp_idx = 2'd2; bp_addr = 8'h03; bp_valid = 1'b0;
    tick();
    bp_we = 1'b0;
    pc = 8'h00;
    SPEEDRUN = 1'b1;
    tick();
    SPEEDRUN = 1'b0;
    for (int k = 1; k <= 7; k++) begin
`ifdef CPU_BREAKPOINT_EN
      sb.push_back(mk(k < 6, (k < 6) ? ST_SPEED : ST_HALTED, k == 6));
`else
      sb.push_back(mk(1'b1, ST_SPEED, 1'b0));
`endif
      tick();
      e = sb.pop_front();
      checks++;
      if ({step_en, mode, bp_hit} !== e) begin
        errors++;
        $display("FAIL bp[%0d]: step_en/mode/bp_hit got %b/%0d/%b exp %b/%0d/%b pc %0d",
                 k, step_en, mode, bp_hit, e.step, e.mode, e.bp, pc);
      end
      if (step_en) pc = pc + 8'd1;
    end
    for (int i = 0; i < 4; i++) begin
`ifdef CPU_BREAKPOINT_EN
      NEXT = (i == 0) || (i == 2);
      sb.push_back(mk(i == 2, ST_IDLE, 1'b0));
`else
      SPEEDRUN = (i == 0);
      sb.push_back(mk(1'b0, ST_IDLE, 1'b0));
`endif
      tick();
      e = sb.pop_front();
      checks++;
      if ({step_en, mode, bp_hit} !== e) begin
        errors++;
        $display("FAIL bp_exit[%0d]: step_en/mode/bp_hit got %b/%0d/%b exp %b/%0d/%b",
                 i, step_en, mode, bp_hit, e.step, e.mode, e.bp);
      end
    end
    NEXT = 1'b0;
    SPEEDRUN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_next();
    test_run();
    test_priority();
    test_speed_halt();
    test_edit();
    test_reset_midrun();
    test_breakpoint();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
